// File: rtl/mux_nx1_seq_pkg.sv
// Shared types and constants for the mux_nx1_seq channel selector.
// Optional feature macro: MUXSEQ_MASK_EN (per-channel enable mask).
package mux_seq_pkg;

  // Sequencer states: IDLE streams manual beats, SCAN sweeps all channels,
  // FLUSH waits for the last sweep beat to leave the output register.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } mux_state_e;

  localparam logic MUX_MODE_MANUAL = 1'b0;
  localparam logic MUX_MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nx1_seq_if.sv
// Bus interface of mux_nx1_seq: packed channel inputs, control, and the
// registered output beat with its valid/ready handshake.
// With MUXSEQ_MASK_EN defined the interface also carries ch_mask.
interface mux_nx1_seq_if #(
  parameter int NCH   = 16,
  parameter int WIDTH = 1
);
  localparam int SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0] i_data;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic                 start;
`ifdef MUXSEQ_MASK_EN
  logic [NCH-1:0]       ch_mask;
`endif
  logic [WIDTH-1:0]     y;
  logic [SELW-1:0]      y_ch;
  logic                 y_err;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;

  // Producer of channel data / consumer of beats (bench or surrounding logic).
  modport master (
    output i_data, mode, sel, start, out_ready,
    input  y, y_ch, y_err, out_valid, busy, done
`ifdef MUXSEQ_MASK_EN
    , output ch_mask
`endif
  );

  // The selector itself.
  modport slave (
    input  i_data, mode, sel, start, out_ready,
    output y, y_ch, y_err, out_valid, busy, done
`ifdef MUXSEQ_MASK_EN
    , input ch_mask
`endif
  );

endinterface

// File: rtl/mux_nx1_seq_next_en.sv
// mux_next_en: priority search for the lowest enabled channel index that is
// >= from_i. none_o is set when no enabled channel remains at or above from_i.
// Only instantiated when MUXSEQ_MASK_EN is defined.
module mux_next_en #(
  parameter  int NCH  = 16,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  mask_i,
  input  logic [SELW-1:0] from_i,
  output logic [SELW-1:0] next_o,
  output logic            none_o
);

  // Descending scan so the lowest qualifying index is the one that sticks.
  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise a path
    // that matches nothing would have to remember the old value (a latch).
    next_o = '0;
    none_o = 1'b1;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask_i[k] && (k >= int'(from_i))) begin
        next_o = SELW'(k);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_seq.sv
// mux_nx1_seq: registered N:1 channel selector with manual and scan modes.
// Manual mode streams ch[sel] continuously; scan mode sweeps every channel
// once per start and pulses done after the last beat is accepted.
// Optional feature macro: MUXSEQ_MASK_EN adds ch_mask; masked channels are
// skipped in scan and flagged with y_err in manual mode.
module mux_nx1_seq
  import mux_seq_pkg::*;
#(
  parameter int NCH   = 16,
  parameter int WIDTH = 1
) (
  input logic           clk,
  input logic           rst_n,
  mux_nx1_seq_if.slave  bus
);

  localparam int              SELW     = $clog2(NCH);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(NCH - 1);

  mux_state_e       state_q, state_d;
  logic [SELW-1:0]  cnt_q,   cnt_d;
  logic [WIDTH-1:0] y_q,     y_d;
  logic [SELW-1:0]  y_ch_q,  y_ch_d;
  logic             y_err_q, y_err_d;
  logic             valid_q, valid_d;
  logic             done_q,  done_d;

  logic             free;       // output register can take a new beat
  logic [SELW-1:0]  scan_idx;   // channel the sweep loads next
  logic             scan_none;  // no channel left to load in this sweep
  logic [SELW-1:0]  rd_idx;     // channel driven into the read mux
  logic [WIDTH-1:0] rd_data;
  logic             sel_en;     // manual sel names an existing, enabled channel

  assign free = !valid_q || bus.out_ready;

`ifdef MUXSEQ_MASK_EN
  mux_next_en #(
    .NCH (NCH)
  ) u_next_en (
    .mask_i (bus.ch_mask),
    .from_i (cnt_q),
    .next_o (scan_idx),
    .none_o (scan_none)
  );
`else
  // All channels enabled: the counter itself is the next index, and the
  // sweep always ends through LAST_IDX, never through scan_none.
  assign scan_idx  = cnt_q;
  assign scan_none = 1'b0;
`endif

  // The read mux serves sel in IDLE and the sweep index otherwise.
  assign rd_idx = (state_q == IDLE) ? bus.sel : scan_idx;

  // Read mux and manual-select validity; an index >= NCH matches no channel,
  // so it yields zero data and sel_en = 0 without a separate range compare.
  always_comb begin
    rd_data = '0;
    sel_en  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (SELW'(k) == rd_idx) begin
        rd_data = bus.i_data[k*WIDTH +: WIDTH];
      end
      if (SELW'(k) == bus.sel) begin
`ifdef MUXSEQ_MASK_EN
        sel_en = bus.ch_mask[k];
`else
        sel_en = 1'b1;
`endif
      end
    end
  end

  // Next-state and output-register load logic for the three-state sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    y_ch_d  = y_ch_q;
    y_err_d = y_err_q;
    valid_d = valid_q && !bus.out_ready;  // an accepted beat leaves unless reloaded
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mode == MUX_MODE_SCAN) begin
          // A held manual beat stays put until accepted; no new manual loads.
          if (bus.start) begin
            cnt_d   = '0;
            state_d = SCAN;
          end
        end else if (free) begin
          y_d     = sel_en ? rd_data : '0;
          y_ch_d  = bus.sel;
          y_err_d = !sel_en;
          valid_d = 1'b1;
        end
      end

      SCAN: begin
        if (scan_none) begin
          // Nothing left to load: finish now if the register is empty or
          // draining this cycle, otherwise wait in FLUSH.
          if (free) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = FLUSH;
          end
        end else if (free) begin
          y_d     = rd_data;
          y_ch_d  = scan_idx;
          y_err_d = 1'b0;
          valid_d = 1'b1;
          if (scan_idx == LAST_IDX) begin
            // No wrap: the highest channel ends the sweep.
            cnt_d   = scan_idx;
            state_d = FLUSH;
          end else begin
            cnt_d   = scan_idx + SELW'(1);
          end
        end
      end

      FLUSH: begin
        if (free) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sweep without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      y_ch_q  <= '0;
      y_err_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      y_ch_q  <= y_ch_d;
      y_err_q <= y_err_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.y_ch      = y_ch_q;
  assign bus.y_err     = y_err_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mux_nx1_seq.sv
// Directed testbench for mux_nx1_seq. Three instances share clock and reset:
// dut_m (NCH=16, WIDTH=1) manual select, dut_n (NCH=10, WIDTH=1) out-of-range
// select, dut_s (NCH=16, WIDTH=8) scan sweeps. Mask tests are built only when
// MUXSEQ_MASK_EN is defined.
module tb_mux_nx1_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  mux_nx1_seq_if #(.NCH(16), .WIDTH(1)) bm ();
  mux_nx1_seq_if #(.NCH(10), .WIDTH(1)) bn ();
  mux_nx1_seq_if #(.NCH(16), .WIDTH(8)) bs ();

  mux_nx1_seq #(.NCH(16), .WIDTH(1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bm.slave));
  mux_nx1_seq #(.NCH(10), .WIDTH(1)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bn.slave));
  mux_nx1_seq #(.NCH(16), .WIDTH(8)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs.slave));

  // Channel k carries 8'hA0 + k.
  function automatic logic [127:0] make_ramp();
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'hA0 + 8'(k);
    return r;
  endfunction

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep();
    bs.mode  = 1'b1;
    bs.start = 1'b1;
    tick();
    bs.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bm.i_data = 16'h5352; bm.mode = 1'b0; bm.sel = '0; bm.start = 1'b0; bm.out_ready = 1'b1;
    bn.i_data = 10'h3FF;  bn.mode = 1'b0; bn.sel = '0; bn.start = 1'b0; bn.out_ready = 1'b1;
    bs.i_data = make_ramp(); bs.mode = 1'b0; bs.sel = '0; bs.start = 1'b0; bs.out_ready = 1'b1;
`ifdef MUXSEQ_MASK_EN
    bm.ch_mask = '1; bn.ch_mask = '1; bs.ch_mask = '1;
`endif
    repeat (2) tick();
    n_vec++; if (bs.y !== 8'h00) begin n_mis++; $display("FAIL reset_y got %h exp 00", bs.y); end
    n_vec++; if (bs.y_ch !== 4'd0) begin n_mis++; $display("FAIL reset_y_ch got %0d exp 0", bs.y_ch); end
    n_vec++; if (bs.y_err !== 1'b0) begin n_mis++; $display("FAIL reset_y_err got %b exp 0", bs.y_err); end
    n_vec++; if (bs.out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid got %b exp 0", bs.out_valid); end
    n_vec++; if (bs.busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %b exp 0", bs.busy); end
    n_vec++; if (bs.done !== 1'b0) begin n_mis++; $display("FAIL reset_done got %b exp 0", bs.done); end
    n_vec++;
    if ({bm.y, bm.y_ch, bm.y_err, bm.out_valid, bm.busy, bm.done} !== '0) begin
      n_mis++; $display("FAIL reset_dut_m got y=%b ch=%0d v=%b", bm.y, bm.y_ch, bm.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_manual();
    // 16'h5352: bits 0,1,14,15,6,4 -> 0,1,1,0,1,1
    logic [3:0] sel_v [6] = '{4'd0, 4'd1, 4'd14, 4'd15, 4'd6, 4'd4};
    logic       exp_v [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bm.i_data = 16'h5352;
    bm.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bm.sel = sel_v[i];
      tick();
      n_vec++;
      if ({bm.y, bm.y_ch, bm.y_err, bm.out_valid} !== {exp_v[i], sel_v[i], 1'b0, 1'b1}) begin
        n_mis++;
        $display("FAIL manual sel=%0d got y=%b ch=%0d err=%b v=%b exp y=%b ch=%0d err=0 v=1",
                 sel_v[i], bm.y, bm.y_ch, bm.y_err, bm.out_valid, exp_v[i], sel_v[i]);
      end
    end
    // Stall: new sel and data must not reach the output while ready is low.
    bm.out_ready = 1'b0;
    bm.sel = 4'd0;
    bm.i_data = 16'h0000;
    repeat (2) tick();
    n_vec++;
    if ({bm.y, bm.y_ch, bm.out_valid} !== {1'b1, 4'd4, 1'b1}) begin
      n_mis++; $display("FAIL manual_stall got y=%b ch=%0d v=%b exp y=1 ch=4 v=1", bm.y, bm.y_ch, bm.out_valid);
    end
    bm.out_ready = 1'b1;
    tick();
    n_vec++;
    if ({bm.y, bm.y_ch} !== {1'b0, 4'd0}) begin
      n_mis++; $display("FAIL manual_resume got y=%b ch=%0d exp y=0 ch=0", bm.y, bm.y_ch);
    end
    bm.i_data = 16'h5352;
  endtask

  task automatic test_manual_range();
    logic [3:0] sel_v [4] = '{4'd12, 4'd9, 4'd15, 4'd0};
    logic       y_v   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       e_v   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bn.i_data = 10'h3FF;
    bn.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bn.sel = sel_v[i];
      tick();
      n_vec++;
      if ({bn.y, bn.y_ch, bn.y_err} !== {y_v[i], sel_v[i], e_v[i]}) begin
        n_mis++;
        $display("FAIL range sel=%0d got y=%b ch=%0d err=%b exp y=%b ch=%0d err=%b",
                 sel_v[i], bn.y, bn.y_ch, bn.y_err, y_v[i], sel_v[i], e_v[i]);
      end
    end
  endtask

  task automatic test_scan();
    bs.i_data = make_ramp();
    bs.out_ready = 1'b1;
    start_sweep();
    n_vec++;
    if ({bs.busy, bs.out_valid} !== 2'b10) begin
      n_mis++; $display("FAIL scan_enter got busy=%b v=%b exp busy=1 v=0", bs.busy, bs.out_valid);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      n_vec++;
      if ({bs.out_valid, bs.y, bs.y_ch, bs.done, bs.busy} !== {1'b1, 8'hA0 + 8'(k), 4'(k), 1'b0, 1'b1}) begin
        n_mis++;
        $display("FAIL scan_beat k=%0d got v=%b y=%h ch=%0d done=%b busy=%b exp y=%h ch=%0d",
                 k, bs.out_valid, bs.y, bs.y_ch, bs.done, bs.busy, 8'hA0 + 8'(k), k);
      end
    end
    tick();
    n_vec++;
    if ({bs.done, bs.busy, bs.out_valid} !== 3'b100) begin
      n_mis++; $display("FAIL scan_done got done=%b busy=%b v=%b exp 1 0 0", bs.done, bs.busy, bs.out_valid);
    end
    tick();
    n_vec++;
    if (bs.done !== 1'b0) begin n_mis++; $display("FAIL scan_done_pulse got %b exp 0", bs.done); end
  endtask

  task automatic test_stall();
    int exp_k = 0;
    int stall_left = 3;
    bit got_done = 1'b0;
    start_sweep();
    for (int c = 0; c < 80 && !got_done; c++) begin
      if (bs.out_valid && bs.y_ch == 4'd5 && stall_left > 0) begin
        bs.out_ready = 1'b0;
        bs.i_data = '1;
        stall_left--;
        n_vec++;
        if ({bs.y, bs.y_ch} !== {8'hA5, 4'd5}) begin
          n_mis++; $display("FAIL stall_hold got y=%h ch=%0d exp y=a5 ch=5", bs.y, bs.y_ch);
        end
      end else begin
        bs.out_ready = 1'b1;
        bs.i_data = make_ramp();
      end
      if (bs.out_valid && bs.out_ready) begin
        n_vec++;
        if ({bs.y, bs.y_ch} !== {8'hA0 + 8'(exp_k), 4'(exp_k)}) begin
          n_mis++; $display("FAIL stall_beat got y=%h ch=%0d exp y=%h ch=%0d",
                            bs.y, bs.y_ch, 8'hA0 + 8'(exp_k), exp_k);
        end
        exp_k++;
      end
      tick();
      if (bs.done) got_done = 1'b1;
    end
    bs.out_ready = 1'b1;
    bs.i_data = make_ramp();
    n_vec++;
    if (!(got_done && exp_k == 16 && stall_left == 0)) begin
      n_mis++; $display("FAIL stall_summary got beats=%0d done=%b stalls_left=%0d exp 16 1 0",
                        exp_k, got_done, stall_left);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    bit done_seen = 1'b0;
    start_sweep();
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (bs.out_valid && bs.y_ch == 4'd7) found = 1'b1;
    end
    n_vec++;
    if (!found) begin n_mis++; $display("FAIL rstmid_reach got no beat 7 exp beat 7"); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bs.y, bs.y_ch, bs.y_err, bs.out_valid, bs.busy, bs.done} !== '0) begin
      n_mis++; $display("FAIL rstmid_clear got y=%h ch=%0d v=%b busy=%b exp all 0",
                        bs.y, bs.y_ch, bs.out_valid, bs.busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bs.done || bs.busy || bs.out_valid) done_seen = 1'b1;
    end
    n_vec++;
    if (done_seen) begin n_mis++; $display("FAIL rstmid_idle got activity after abort exp none"); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    bit got = 1'b0;
    bs.mode = 1'b1;
    bs.start = 1'b1;
    bs.out_ready = 1'b1;
    tick();
    for (int c = 1; c <= 40 && !got; c++) begin
      tick();
      if (bs.done) begin got = 1'b1; cyc = c; end
    end
    n_vec++;
    if (cyc != 17) begin n_mis++; $display("FAIL b2b_first_done got cycle %0d exp 17", cyc); end
    tick();
    n_vec++;
    if ({bs.busy, bs.done} !== 2'b10) begin
      n_mis++; $display("FAIL b2b_retrigger got busy=%b done=%b exp 1 0", bs.busy, bs.done);
    end
    bs.start = 1'b0;
    got = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      tick();
      if (bs.done) begin got = 1'b1; cyc = c; end
    end
    n_vec++;
    if (cyc != 17) begin n_mis++; $display("FAIL b2b_second_done got cycle %0d exp 17", cyc); end
  endtask

`ifdef MUXSEQ_MASK_EN
  task automatic test_mask();
    logic [3:0] exp_ch [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
    int  nb = 0;
    bit  got = 1'b0;
    bit  saw_valid = 1'b0;
    bs.ch_mask = 16'h8421;
    bs.out_ready = 1'b1;
    start_sweep();
    for (int c = 0; c < 40 && !got; c++) begin
      if (bs.out_valid) begin
        n_vec++;
        if (nb > 3 || {bs.y, bs.y_ch} !== {8'hA0 + 8'(exp_ch[nb & 3]), exp_ch[nb & 3]}) begin
          n_mis++; $display("FAIL mask_beat n=%0d got y=%h ch=%0d", nb, bs.y, bs.y_ch);
        end
        nb++;
      end
      tick();
      if (bs.done) got = 1'b1;
    end
    n_vec++;
    if (!(got && nb == 4)) begin n_mis++; $display("FAIL mask_count got beats=%0d done=%b exp 4 1", nb, got); end
    // All channels masked: done one cycle after entering SCAN, no beats.
    bs.ch_mask = '0;
    start_sweep();
    if (bs.out_valid) saw_valid = 1'b1;
    tick();
    if (bs.out_valid) saw_valid = 1'b1;
    n_vec++;
    if ({bs.done, saw_valid} !== 2'b10) begin
      n_mis++; $display("FAIL mask_zero got done=%b valid_seen=%b exp 1 0", bs.done, saw_valid);
    end
    // Manual select of a masked channel is flagged.
    bs.ch_mask = 16'h8421;
    bs.mode = 1'b0;
    bs.sel = 4'd1;
    tick();
    n_vec++;
    if ({bs.y, bs.y_ch, bs.y_err} !== {8'h00, 4'd1, 1'b1}) begin
      n_mis++; $display("FAIL mask_manual got y=%h ch=%0d err=%b exp 00 1 1", bs.y, bs.y_ch, bs.y_err);
    end
    bs.sel = 4'd5;
    tick();
    n_vec++;
    if ({bs.y, bs.y_ch, bs.y_err} !== {8'hA5, 4'd5, 1'b0}) begin
      n_mis++; $display("FAIL mask_manual_en got y=%h ch=%0d err=%b exp a5 5 0", bs.y, bs.y_ch, bs.y_err);
    end
    bs.ch_mask = '1;
  endtask
`endif

  initial begin
    test_reset();
    test_manual();
    test_manual_range();
    test_scan();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef MUXSEQ_MASK_EN
    test_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mux_nx1_seq.md
# mux_nx1_seq

Parametrised, registered N:1 channel selector; successor to the fixed 16:1 combinational mux. Selects one WIDTH-bit channel from a packed input bus. In manual mode the channel comes from `sel`; in scan mode an internal counter sweeps all channels once per `start`. Output is a registered beat with a valid/ready handshake, so it feeds streaming consumers (serialisers, loggers) directly.

## Interface
- `NCH`, 16, number of input channels (2..256, need not be a power of 2)
- `WIDTH`, 1, bits per channel
- `SELW`, `$clog2(NCH)`, select/channel-index width (derived, not overridden)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_data`  in  NCH*WIDTH  packed channels; channel k = `i_data[k*WIDTH +: WIDTH]`
- `mode`  in  1  0 = manual, 1 = scan; sampled only in IDLE
- `sel`  in  SELW  manual-mode channel index
- `start`  in  1  scan-mode sweep request (level or pulse; acted on in IDLE only)
- `ch_mask`  in  NCH  channel enable mask (present only with MUXSEQ_MASK_EN)
- `y`  out  WIDTH  selected channel data (registered)
- `y_ch`  out  SELW  channel index of the current beat
- `y_err`  out  1  beat carries an invalid index (`sel` >= NCH, or masked channel)
- `out_valid`  out  1  beat present on `y`/`y_ch`/`y_err`
- `out_ready`  in  1  consumer accepts beat
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse: sweep finished

## Operation
- States: IDLE, SCAN, FLUSH.
- Output register "free" = `!out_valid || out_ready`. Beat transfer = `out_valid && out_ready`.
- IDLE, `mode`=0: every free cycle loads `y = ch[sel]`, `y_ch = sel`, `y_err = 0`; `out_valid` = 1 thereafter (continuous stream, re-sampled each accepted beat). If `sel` >= NCH: `y` = 0, `y_ch` = sel, `y_err` = 1.
- IDLE, `mode`=1, `start`=1: counter := 0, go SCAN, `busy` = 1. Manual loading stops; any held beat stays until accepted.
- SCAN: each free cycle loads `ch[cnt]`, `y_ch = cnt`, cnt++. After loading cnt = NCH-1, go FLUSH (no wrap within a sweep).
- FLUSH: wait for last beat transfer; then `done` = 1 for one cycle, `busy` = 0, `out_valid` = 0, go IDLE.
- `start`, `mode`, `sel` ignored outside IDLE. `start` held high re-triggers a new sweep the cycle after `done`.
- `i_data` sampled at load time; changes while a beat is stalled do not alter `y`.

## Timing
- Reset (async assert, sync-released use of `rst_n`): `y`=0, `y_ch`=0, `y_err`=0, `out_valid`=0, `busy`=0, `done`=0, cnt=0, state IDLE.
- Latency: input sampled at edge N appears on `y` after edge N (1 cycle).
- Throughput: one beat per cycle with `out_ready` held high; full sweep = NCH beats, `done` asserted in the cycle after the last transfer (NCH+1 cycles after start edge).
- Stall: `out_ready`=0 with `out_valid`=1 holds all outputs and counter stable.
- Reset mid-sweep: immediate abort, no `done`.

## Configuration
- `MUXSEQ_MASK_EN` defined: `ch_mask` port exists. SCAN skips channels with mask bit 0 (counter advances to next enabled index in the same cycle, combinational priority search). All-zero mask: start -> `done` next cycle, no beats. Manual `sel` on a masked channel -> `y`=0, `y_err`=1.
- Undefined: no `ch_mask` port; all channels treated as enabled.

## Structure
- Shared package `mux_seq_pkg`: state enum (IDLE/SCAN/FLUSH), `MUX_MODE_MANUAL`/`MUX_MODE_SCAN` constants.
- One sub-module `mux_next_en`: given mask and current index, returns next enabled index and "none left" flag (used only with MUXSEQ_MASK_EN).

## Test plan
- Manual, NCH=16, WIDTH=1, `i_data`=16'h5352, `sel`=4, ready=1 -> next cycle `y`=1, `y_ch`=4, `y_err`=0.
- Manual, NCH=10, `sel`=12 -> `y`=0, `y_ch`=12, `y_err`=1.
- Scan, NCH=16, WIDTH=8, channel k = k+8'hA0, ready=1 -> 16 beats A0..AF, `y_ch` 0..15, `done` once, one cycle after last beat.
- Scan with `out_ready` low at beat 5 for 3 cycles -> `y`=A5, `y_ch`=5 held 3 cycles, no beat lost or duplicated.
- `rst_n` pulsed low at beat 7 of sweep -> all outputs 0 immediately, no `done`, IDLE.
- MUXSEQ_MASK_EN, `ch_mask`=16'h8421 -> beats on channels 0,5,10,15 only, then `done`; mask 0 -> `done` with zero beats.
